pipe_ctrl_sequencer: RTL and testbench

PIPE_CTRL_SEQUENCER -- requirements
Module: pipe_ctrl_sequencer

---
 rtl/superscalar_pkg.sv | 14 +
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_ctrl_sequencer.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/superscalar_pkg.sv
// Shared definitions for the pipeline-control sequencer: PC width and the
// sequencer state encoding exported on the state port.
package superscalar_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_RECOVER = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that increments on inc and holds at its all-ones value.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on request, stop at full scale, clear on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// Pipeline control sequencer: stalls dispatch when resources run short and
// runs a timed flush/redirect sequence on branch mispredicts and after reset.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   RUN     | normal dispatch, no stall
//   STALL   | resources short or external stall; front end frozen
//   FLUSH   | squashing speculative state, held for FLUSH_CYCLES cycles
//   RECOVER | single settling cycle after a flush before dispatch resumes
module pipe_ctrl_sequencer
    import superscalar_pkg::*;
#(
    parameter int              ROB_CNT_W      = 7,
    parameter int              RS_CNT_W       = 5,
    parameter int              DISPATCH_WIDTH = 2,
    parameter int              FLUSH_CYCLES   = 3,
    parameter logic [PC_W-1:0] RESET_PC       = 16'h0000,
    parameter int              STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ext_stall,
    input  logic [ROB_CNT_W-1:0]   rob_free,
    input  logic [RS_CNT_W-1:0]    rs_al_free,
    input  logic [RS_CNT_W-1:0]    rs_ls_free,
    input  logic                   mispredict_valid,
    input  logic [PC_W-1:0]        mispredict_target,
    output logic                   stall,
    output logic                   flush,
    output logic                   redirect_valid,
    output logic [PC_W-1:0]        redirect_pc,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [7:0]             flush_count
);

    localparam logic [3:0]           FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [ROB_CNT_W-1:0] ROB_MIN    = ROB_CNT_W'(DISPATCH_WIDTH);
    localparam logic [RS_CNT_W-1:0]  RS_MIN     = RS_CNT_W'(DISPATCH_WIDTH);

    seq_state_t cur;
    logic [3:0] flush_cnt;
    logic       short_res;
    logic       mp_accept;
    logic       stall_inc;

    // Resource shortage and mispredict acceptance; FLUSH is deaf to mispredicts.
    always_comb begin
        short_res = (rob_free < ROB_MIN) || (rs_al_free < RS_MIN) ||
                    (rs_ls_free < RS_MIN) || ext_stall;
        mp_accept = mispredict_valid && (cur != ST_FLUSH);
        stall_inc = (cur == ST_STALL);
    end

    // Sequencer FSM; outputs are registered alongside the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur            <= ST_FLUSH;
            flush_cnt      <= FLUSH_LOAD;
            stall          <= 1'b1;
            flush          <= 1'b1;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
        end else begin
            case (cur)
                ST_RUN, ST_STALL, ST_RECOVER: begin
                    if (mispredict_valid) begin
                        cur            <= ST_FLUSH;
                        flush_cnt      <= FLUSH_LOAD;
                        stall          <= 1'b1;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= mispredict_target;
                    end else if (short_res) begin
                        cur            <= ST_STALL;
                        stall          <= 1'b1;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b0;
                    end else begin
                        cur            <= ST_RUN;
                        stall          <= 1'b0;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    redirect_valid <= 1'b0;
                    if (flush_cnt == 4'd0) begin
                        cur   <= ST_RECOVER;
                        stall <= 1'b1;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                        stall     <= 1'b1;
                        flush     <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable with a 2-bit enum, but fall back to a clean flush.
                    cur            <= ST_FLUSH;
                    flush_cnt      <= FLUSH_LOAD;
                    stall          <= 1'b1;
                    flush          <= 1'b1;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur;

    sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(8)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mp_accept),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// Directed bench for pipe_ctrl_sequencer: reset flush sequence, resource
// stalls, mispredict flushes, priority, saturation and async reset abort.
module tb_pipe_ctrl_sequencer;

    localparam logic [15:0] RPC = 16'h0100;
    localparam logic [1:0]  S_RUN = 2'd0, S_STALL = 2'd1, S_FLUSH = 2'd2, S_REC = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ext_stall = 1'b0;
    logic [6:0]  rob_free = 7'd7;
    logic [4:0]  rs_al_free = 5'd8;
    logic [4:0]  rs_ls_free = 5'd8;
    logic        mispredict_valid = 1'b0;
    logic [15:0] mispredict_target = 16'h0;
    logic        stall, flush, redirect_valid;
    logic [15:0] redirect_pc;
    logic [1:0]  state;
    logic [7:0]  stall_cycles;
    logic [7:0]  flush_count;

    int total = 0;
    int bad = 0;
    int exp_fc = 0;

    pipe_ctrl_sequencer #(
        .ROB_CNT_W(7), .RS_CNT_W(5), .DISPATCH_WIDTH(2), .FLUSH_CYCLES(3),
        .RESET_PC(RPC), .STALL_CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .ext_stall(ext_stall), .rob_free(rob_free),
        .rs_al_free(rs_al_free), .rs_ls_free(rs_ls_free),
        .mispredict_valid(mispredict_valid), .mispredict_target(mispredict_target),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .state(state), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int nf, ns, nrv;
        nf = 0; ns = 0; nrv = 0;
        step(); step();
        total++;
        if (state !== S_FLUSH || flush !== 1'b1 || stall !== 1'b1 || redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: state=%0d flush=%b stall=%b rv=%b, want 2 1 1 0", state, flush, stall, redirect_valid);
        end
        total++;
        if (redirect_pc !== RPC || stall_cycles !== 8'd0 || flush_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_regs: pc=%h sc=%0d fc=%0d, want %h 0 0", redirect_pc, stall_cycles, flush_count, RPC);
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (flush === 1'b1) nf++;
            if (stall === 1'b1) ns++;
            if (redirect_valid !== 1'b0) nrv++;
            step();
        end
        total++;
        if (nf != 3 || ns != 4 || nrv != 0) begin
            bad++;
            $display("FAIL reset_seq: flush_cyc=%0d stall_cyc=%0d rv_cyc=%0d, want 3 4 0", nf, ns, nrv);
        end
        total++;
        if (state !== S_RUN) begin
            bad++;
            $display("FAIL reset_end_state: got %0d want 0", state);
        end
    endtask

    task automatic test_rob_stall();
        rob_free = 7'd1;
        step();
        total++;
        if (state !== S_STALL || stall !== 1'b1 || flush !== 1'b0) begin
            bad++;
            $display("FAIL rob_stall_enter: state=%0d stall=%b flush=%b, want 1 1 0", state, stall, flush);
        end
        step(); step(); step(); step();
        rob_free = 7'd7;
        step();
        total++;
        if (state !== S_RUN || stall !== 1'b0) begin
            bad++;
            $display("FAIL rob_stall_exit: state=%0d stall=%b, want 0 0", state, stall);
        end
        total++;
        if (stall_cycles !== 8'd5) begin
            bad++;
            $display("FAIL rob_stall_count: got %0d want 5", stall_cycles);
        end
        rs_ls_free = 5'd1;
        step();
        total++;
        if (state !== S_STALL) begin
            bad++;
            $display("FAIL rs_ls_stall: got %0d want 1", state);
        end
        rs_ls_free = 5'd2;
        step();
        total++;
        if (state !== S_RUN) begin
            bad++;
            $display("FAIL rs_ls_boundary: got %0d want 0", state);
        end
    endtask

    task automatic test_mispredict();
        mispredict_valid = 1'b1; mispredict_target = 16'h0040;
        step();
        mispredict_valid = 1'b0;
        exp_fc++;
        total++;
        if (state !== S_FLUSH || flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 16'h0040) begin
            bad++;
            $display("FAIL mp_enter: state=%0d flush=%b rv=%b pc=%h, want 2 1 1 0040", state, flush, redirect_valid, redirect_pc);
        end
        total++;
        if (flush_count !== 8'(exp_fc)) begin
            bad++;
            $display("FAIL mp_count: got %0d want %0d", flush_count, exp_fc);
        end
        step();
        total++;
        if (redirect_valid !== 1'b0 || flush !== 1'b1) begin
            bad++;
            $display("FAIL mp_second_cycle: rv=%b flush=%b, want 0 1", redirect_valid, flush);
        end
        step();
        total++;
        if (flush !== 1'b1) begin
            bad++;
            $display("FAIL mp_third_cycle: flush=%b want 1", flush);
        end
        step();
        total++;
        if (state !== S_REC || flush !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL mp_recover: state=%0d flush=%b stall=%b, want 3 0 1", state, flush, stall);
        end
        step();
        total++;
        if (state !== S_RUN || stall !== 1'b0) begin
            bad++;
            $display("FAIL mp_run: state=%0d stall=%b, want 0 0", state, stall);
        end
    endtask

    task automatic test_stall_priority();
        ext_stall = 1'b1;
        step();
        total++;
        if (state !== S_STALL) begin
            bad++;
            $display("FAIL ext_stall_enter: got %0d want 1", state);
        end
        mispredict_valid = 1'b1; mispredict_target = 16'h0080;
        step();
        exp_fc++;
        total++;
        if (state !== S_FLUSH || redirect_pc !== 16'h0080 || flush_count !== 8'(exp_fc)) begin
            bad++;
            $display("FAIL stall_mp_priority: state=%0d pc=%h fc=%0d, want 2 0080 %0d", state, redirect_pc, flush_count, exp_fc);
        end
        mispredict_target = 16'h00C0;
        step();
        mispredict_valid = 1'b0;
        total++;
        if (state !== S_FLUSH || redirect_pc !== 16'h0080 || flush_count !== 8'(exp_fc) || redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_ignores_mp: state=%0d pc=%h fc=%0d rv=%b, want 2 0080 %0d 0", state, redirect_pc, flush_count, redirect_valid, exp_fc);
        end
        step(); step();
        total++;
        if (state !== S_REC) begin
            bad++;
            $display("FAIL flush_len_after_ignore: got %0d want 3", state);
        end
        step();
        total++;
        if (state !== S_STALL) begin
            bad++;
            $display("FAIL recover_to_stall: got %0d want 1", state);
        end
        ext_stall = 1'b0;
        step();
    endtask

    task automatic test_recover_mispredict();
        mispredict_valid = 1'b1; mispredict_target = 16'h0100;
        step();
        mispredict_valid = 1'b0;
        exp_fc++;
        step(); step(); step();
        total++;
        if (state !== S_REC) begin
            bad++;
            $display("FAIL rec_reach: got %0d want 3", state);
        end
        mispredict_valid = 1'b1; mispredict_target = 16'h0200;
        step();
        mispredict_valid = 1'b0;
        exp_fc++;
        total++;
        if (state !== S_FLUSH || redirect_valid !== 1'b1 || redirect_pc !== 16'h0200 || flush_count !== 8'(exp_fc)) begin
            bad++;
            $display("FAIL rec_mp_reenter: state=%0d rv=%b pc=%h fc=%0d, want 2 1 0200 %0d", state, redirect_valid, redirect_pc, flush_count, exp_fc);
        end
        step(); step(); step(); step();
        total++;
        if (state !== S_RUN) begin
            bad++;
            $display("FAIL rec_mp_run: got %0d want 0", state);
        end
    endtask

    task automatic test_saturation_and_reset();
        ext_stall = 1'b1;
        for (int i = 0; i < 300; i++) step();
        total++;
        if (state !== S_STALL || stall_cycles !== 8'hFF) begin
            bad++;
            $display("FAIL stall_sat: state=%0d sc=%h, want 1 ff", state, stall_cycles);
        end
        ext_stall = 1'b0;
        step();
        for (int i = 0; i < 260; i++) begin
            mispredict_valid = 1'b1; mispredict_target = 16'(i);
            step();
            mispredict_valid = 1'b0;
            step(); step(); step();
        end
        total++;
        if (flush_count !== 8'hFF || state !== S_REC) begin
            bad++;
            $display("FAIL flush_sat: fc=%h state=%0d, want ff 3", flush_count, state);
        end
        mispredict_valid = 1'b1; mispredict_target = 16'h0ABC;
        step();
        mispredict_valid = 1'b0;
        total++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0ABC) begin
            bad++;
            $display("FAIL pre_abort: rv=%b pc=%h, want 1 0abc", redirect_valid, redirect_pc);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (state !== S_FLUSH || flush !== 1'b1 || stall !== 1'b1 || redirect_valid !== 1'b0 || redirect_pc !== RPC) begin
            bad++;
            $display("FAIL async_abort_ctrl: state=%0d flush=%b stall=%b rv=%b pc=%h", state, flush, stall, redirect_valid, redirect_pc);
        end
        total++;
        if (stall_cycles !== 8'd0 || flush_count !== 8'd0) begin
            bad++;
            $display("FAIL async_abort_cnt: sc=%0d fc=%0d, want 0 0", stall_cycles, flush_count);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_rob_stall();
        test_mispredict();
        test_stall_priority();
        test_recover_mispredict();
        test_saturation_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
